// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - shared gated-clock enable controller with wake settle and idle hysteresis
module clk_gate_ctrl #(
  parameter int N_REQ    = 4,
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             force_on,
  output logic             gate_en,
  output logic [N_REQ-1:0] ack,
  output logic             busy,
  output logic [7:0]       wake_count
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               gate_en_q, gate_en_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               busy_q, busy_d;
  logic [7:0]         wake_count_q, wake_count_d;
  logic               any_req;

  // force_on keeps the buffer alive like a request but never earns an ack bit
  assign any_req = (|req) | force_on;

  // Next-state and registered-output computation; ack only ever mirrors req from ON
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gate_en_d    = gate_en_q;
    ack_d        = ack_q;
    wake_count_d = wake_count_q;
    case (state_q)
      ST_OFF: begin
        gate_en_d = 1'b0;
        ack_d     = '0;
        if (any_req) begin
          state_d   = ST_WAKE;
          gate_en_d = 1'b1;
          cnt_d     = WAKE_LOAD;
          if (wake_count_q != 8'd255) begin
            wake_count_d = wake_count_q + 8'd1;
          end
        end
      end
      ST_WAKE: begin
        gate_en_d = 1'b1;
        ack_d     = '0;
        // Settle time is fixed once started; request churn does not restart it
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (any_req) begin
          state_d = ST_ON;
          ack_d   = req;
        end else begin
          state_d = ST_HOLD;
          cnt_d   = IDLE_LOAD;
        end
      end
      ST_ON: begin
        gate_en_d = 1'b1;
        if (any_req) begin
          ack_d = req;
        end else begin
          state_d = ST_HOLD;
          ack_d   = '0;
          cnt_d   = IDLE_LOAD;
        end
      end
      ST_HOLD: begin
        gate_en_d = 1'b1;
        ack_d     = '0;
        // Clock is still running here, so a new request skips the wake delay
        if (any_req) begin
          state_d = ST_ON;
          ack_d   = req;
        end else if (cnt_q == '0) begin
          state_d   = ST_OFF;
          gate_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d   = ST_OFF;
        gate_en_d = 1'b0;
        ack_d     = '0;
        cnt_d     = '0;
      end
    endcase
    busy_d = (state_d != ST_OFF);
  end

  // State and output registers; reset wins over every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      gate_en_q    <= 1'b0;
      ack_q        <= '0;
      busy_q       <= 1'b0;
      wake_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gate_en_q    <= gate_en_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      wake_count_q <= wake_count_d;
    end
  end

  assign gate_en    = gate_en_q;
  assign ack        = ack_q;
  assign busy       = busy_q;
  assign wake_count = wake_count_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb/tb_clk_gate_ctrl.sv - directed self-checking bench for clk_gate_ctrl
module tb_clk_gate_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       force_on;
  logic       gate_en;
  logic [3:0] ack;
  logic       busy;
  logic [7:0] wake_count;

  int n_cmp;
  int n_fail;

  clk_gate_ctrl #(
    .N_REQ(4),
    .WAKE_CYC(2),
    .IDLE_CYC(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .force_on(force_on),
    .gate_en(gate_en),
    .ack(ack),
    .busy(busy),
    .wake_count(wake_count)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One rising edge, then settle to the falling edge for sampling
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic g, input logic [3:0] a,
                           input logic b, input logic [7:0] w);
    check({tag, ".gate_en"}, 32'(gate_en), 32'(g));
    check({tag, ".ack"}, 32'(ack), 32'(a));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".wake_count"}, 32'(wake_count), 32'(w));
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    req      = 4'b1111;
    force_on = 1'b0;
    @(negedge clk);

    // Reset held with all requests asserted
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("reset", 1'b0, 4'b0000, 1'b0, 8'd0);
    end
    rst = 1'b0;
    req = 4'b0000;
    step();
    check_all("idle_after_reset", 1'b0, 4'b0000, 1'b0, 8'd0);

    // Cold request: two WAKE cycles with no ack, then ack
    req = 4'b0001;
    step();
    check_all("cold_wake1", 1'b1, 4'b0000, 1'b1, 8'd1);
    step();
    check_all("cold_wake2", 1'b1, 4'b0000, 1'b1, 8'd1);
    step();
    check_all("cold_ack", 1'b1, 4'b0001, 1'b1, 8'd1);

    // Multi-requester tracking in ON
    req = 4'b0011;
    step();
    check_all("multi_0011", 1'b1, 4'b0011, 1'b1, 8'd1);
    req = 4'b0010;
    step();
    check_all("multi_0010", 1'b1, 4'b0010, 1'b1, 8'd1);

    // Release: four HOLD cycles, then gate off
    req = 4'b0000;
    step();
    check_all("release_hold0", 1'b1, 4'b0000, 1'b1, 8'd1);
    for (int i = 1; i < 4; i++) begin
      step();
      check_all("release_hold", 1'b1, 4'b0000, 1'b1, 8'd1);
    end
    step();
    check_all("release_off", 1'b0, 4'b0000, 1'b0, 8'd1);

    // HOLD re-request: no wake delay, no wake_count increment
    req = 4'b0001;
    step();
    step();
    step();
    check_all("rereq_on", 1'b1, 4'b0001, 1'b1, 8'd2);
    req = 4'b0000;
    step();
    step();
    step();
    check_all("rereq_in_hold", 1'b1, 4'b0000, 1'b1, 8'd2);
    req = 4'b0100;
    step();
    check_all("rereq_ack", 1'b1, 4'b0100, 1'b1, 8'd2);
    req = 4'b0000;
    for (int i = 0; i < 5; i++) step();
    check_all("rereq_off", 1'b0, 4'b0000, 1'b0, 8'd2);

    // force_on from OFF: clock on, never an ack
    force_on = 1'b1;
    step();
    check_all("force_wake", 1'b1, 4'b0000, 1'b1, 8'd3);
    for (int i = 0; i < 4; i++) begin
      step();
      check_all("force_on_noack", 1'b1, 4'b0000, 1'b1, 8'd3);
    end
    force_on = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("force_drop.gate_en", 32'(gate_en), (k < 5) ? 32'd1 : 32'd0);
    end
    check("force_drop.busy", 32'(busy), 32'd0);

    // Reset while in ON with an ack outstanding
    req = 4'b0001;
    step();
    step();
    step();
    check_all("pre_rst_on", 1'b1, 4'b0001, 1'b1, 8'd4);
    rst = 1'b1;
    step();
    check_all("mid_reset", 1'b0, 4'b0000, 1'b0, 8'd0);
    rst = 1'b0;
    req = 4'b0000;
    step();
    check_all("post_reset_idle", 1'b0, 4'b0000, 1'b0, 8'd0);

    // Saturation: 260 complete cold wake / gate-off cycles
    for (int i = 0; i < 260; i++) begin
      req = 4'b0001;
      step();
      req = 4'b0000;
      for (int j = 0; j < 6; j++) step();
      if (i == 253) check("sat_254", 32'(wake_count), 32'd254);
    end
    check_all("sat_255", 1'b0, 4'b0000, 1'b0, 8'd255);
    force_on = 1'b1;
    step();
    check_all("sat_hold", 1'b1, 4'b0000, 1'b1, 8'd255);
    force_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
